// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, defaults, round-constant table and schedule
// sigma functions for the SHA-256 round sequencer.
package sha256_pkg;

    localparam int ROUNDS_DFLT = 64;
    localparam int WORD_W_DFLT = 32;

    typedef logic [WORD_W_DFLT-1:0] word_t;

    typedef enum logic [1:0] {
        st_idle,
        st_init,
        st_round,
        st_finish
    } state_t;

    // First 32 bits of the fractional parts of the cube roots of the first
    // 64 primes, indexed by round number.
    localparam word_t K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Schedule sigma0: ROTR7 ^ ROTR18 ^ SHR3.
    function automatic word_t sig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // Schedule sigma1: ROTR17 ^ ROTR19 ^ SHR10.
    function automatic word_t sig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word sliding message-schedule window. A load copies
// the padded block in (word 0 from the top bits); each shift drops W[0]
// and appends the next expanded word, so W[0] is always W_t of the round.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] blk_data,
    output word_t        w0
);

    word_t win [0:15];
    word_t w_new;

    // Expansion term for the word sixteen positions ahead of W[0].
    always_comb begin
        w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    // Window register: load a fresh block or slide by one word per round.
    // NOTE: the window must read as zero after reset, so every entry is reset
    // explicitly; it is a small register bank, not a RAM, so this is cheap.
    // NOTE: non-blocking assignments make each entry take its neighbour's
    // pre-edge value, which is exactly the shift we want.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= blk_data[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_new;
        end
    end

    assign w0 = win[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: accepts one padded 512-bit block, then sequences the
// 64 compression rounds, presenting W_t/K_t and the soc/eoc/done framing.
// Build option: define SHA256_CTRL_ABORT_EN to add an 'abort' input that
// cancels a run in INIT or ROUND (no eoc/done for that block).
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DFLT,
    parameter int WORD_W = WORD_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [511:0]      blk_data,
    input  logic              blk_first,
`ifdef SHA256_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic [WORD_W-1:0] wt,
    output logic [WORD_W-1:0] kt,
    output logic              round_en,
    output logic              soc,
    output logic              eoc,
    output logic              done
);

    localparam int               CNT_W  = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(ROUNDS - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] t;
    logic             live;
    logic             load;
    logic             shift;
    logic             abort_req;
    word_t            w0;
    word_t            kt_cur;
    logic [WORD_W-1:0] wt_q;
    logic [WORD_W-1:0] kt_q;

`ifdef SHA256_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    sha256_msg_sched u_sched (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .blk_data (blk_data),
        .w0       (w0)
    );

    assign kt_cur = K_TAB[t];

    // State register plus a flag that holds blk_ready low until the first
    // clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_idle;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
        end
    end

    // Next-state and strobe decode. blk_first is only consulted at the
    // accept edge; the INIT/ROUND choice itself records it.
    // NOTE: every output is given a default before the case so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        blk_ready = 1'b0;
        round_en  = 1'b0;
        soc       = 1'b0;
        eoc       = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            st_idle: begin
                blk_ready = live;
                if (blk_valid && live) begin
                    load     = 1'b1;
                    state_nx = blk_first ? st_init : st_round;
                end
            end
            st_init: begin
                soc      = 1'b1;
                state_nx = abort_req ? st_idle : st_round;
            end
            st_round: begin
                round_en = 1'b1;
                shift    = 1'b1;
                if (abort_req) begin
                    state_nx = st_idle;
                end else if (t == LAST_T) begin
                    state_nx = st_finish;
                end
            end
            st_finish: begin
                eoc      = 1'b1;
                done     = 1'b1;
                state_nx = st_idle;
            end
            default: begin
                state_nx = st_idle;
            end
        endcase
    end

    // Round counter: counts consecutive ROUND cycles, zero everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (state == st_round && state_nx == st_round) begin
            t <= t + CNT_W'(1);
        end else begin
            t <= '0;
        end
    end

    // Capture the last presented W_t/K_t so the outputs hold outside ROUND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wt_q <= '0;
            kt_q <= '0;
        end else if (state == st_round) begin
            wt_q <= w0;
            kt_q <= kt_cur;
        end
    end

    assign wt = (state == st_round) ? w0     : wt_q;
    assign kt = (state == st_round) ? kt_cur : kt_q;

endmodule
